// File: rtl/spm_mult_n.sv
// spm_mult_n: sequential shift-add multiplier, one multiplier bit per clock.
// Produces a 2*WIDTH-bit unsigned or two's-complement signed product behind
// a start/done handshake; the result is held in P until the next completion.
// Optional feature macro: SPM_EARLY_TERM_EN (unsigned operations finish as soon
// as the remaining multiplier bits are all zero).
module spm_mult_n #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     MP,
    input  logic [WIDTH-1:0]     MC,
    output logic [2*WIDTH-1:0]   P,
    output logic                 done,
    output logic                 busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mp_r;
    logic [WIDTH-1:0] mc_r;
    logic             sgn_r;
    logic [CW-1:0]    cnt;
`ifdef SPM_EARLY_TERM_EN
    logic [WIDTH-1:0] mrem;
`endif

    logic [WIDTH:0]   acc_x;
    logic [WIDTH:0]   mc_x;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             last_bit;
    logic             step_last;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_out;

    // One shift-add step: extend to WIDTH+1 bits, subtract on the signed MP sign bit
    always_comb begin
        acc_x    = {sgn_r & acc[WIDTH-1], acc};
        mc_x     = {sgn_r & mc_r[WIDTH-1], mc_r};
        last_bit = (cnt == CW'(WIDTH - 1));
        addend   = mp_r[0] ? mc_x : '0;
        sum      = (sgn_r && last_bit) ? (acc_x - addend) : (acc_x + addend);
        prod     = {sum, mp_r[WIDTH-1:1]};
`ifdef SPM_EARLY_TERM_EN
        // Remaining zero bits would only shift the product right; apply that shift now
        step_last = last_bit || (!sgn_r && (mrem[WIDTH-1:1] == '0));
        prod_out  = prod >> (CW'(WIDTH - 1) - cnt);
`else
        step_last = last_bit;
        prod_out  = prod;
`endif
    end

    // Next-state logic: start accepted only outside RUN
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (step_last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            mp_r  <= '0;
            mc_r  <= '0;
            sgn_r <= 1'b0;
            cnt   <= '0;
`ifdef SPM_EARLY_TERM_EN
            mrem  <= '0;
`endif
            P     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            if (accept) begin
                acc   <= '0;
                mp_r  <= MP;
                mc_r  <= MC;
                sgn_r <= sgn;
                cnt   <= '0;
`ifdef SPM_EARLY_TERM_EN
                mrem  <= MP;
`endif
            end else if (state == RUN) begin
                acc  <= sum[WIDTH:1];
                mp_r <= {sum[0], mp_r[WIDTH-1:1]};
                cnt  <= cnt + CW'(1);
`ifdef SPM_EARLY_TERM_EN
                mrem <= mrem >> 1;
`endif
                if (step_last) begin
                    P <= prod_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_spm_mult_n.sv
// tb_spm_mult_n: directed and random checks of spm_mult_n against an
// arithmetic reference (plain multiplication and a latency rule).
module tb_spm_mult_n;

    localparam int unsigned W       = 32;
    localparam int unsigned W8      = 8;
    localparam int          TIMEOUT = 200;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            sgn;
    logic [W-1:0]    mp;
    logic [W-1:0]    mc;
    logic [2*W-1:0]  p;
    logic            done;
    logic            busy;

    logic            start8;
    logic            sgn8;
    logic [W8-1:0]   mp8;
    logic [W8-1:0]   mc8;
    logic [2*W8-1:0] p8;
    logic            done8;
    logic            busy8;

    int checks   = 0;
    int failures = 0;

    spm_mult_n #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .sgn(sgn),
        .MP(mp), .MC(mc), .P(p), .done(done), .busy(busy)
    );

    spm_mult_n #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sgn(sgn8),
        .MP(mp8), .MC(mc8), .P(p8), .done(done8), .busy(busy8)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic int ref_lat(input logic s, input logic [31:0] a);
`ifdef SPM_EARLY_TERM_EN
        int hi;
        if (!s) begin
            hi = 0;
            for (int i = 0; i < 32; i++) if (a[i]) hi = i + 1;
            return (hi == 0) ? 1 : hi;
        end
`endif
        return 32;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operation for one edge, then scramble the inputs
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; sgn = s; mp = a; mc = b;
        @(posedge clk); #1;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_done", 64'(done), 64'd0);
        @(negedge clk);
        start = 1'b0; sgn = 1'($urandom); mp = $urandom; mc = $urandom;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [63:0] exp);
        int n = 0;
        int gaps = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!done && !busy) gaps++;
        end while (!done && n < TIMEOUT);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_P"}, p, exp);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_busy_run"}, 64'(gaps), 64'd0);
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
        launch(s, a, b);
        wait_done(tag, ref_lat(s, a), ref_prod(s, a, b));
        @(posedge clk); #1;
        check({tag, "_hold_done"}, 64'(done), 64'd1);
        check({tag, "_hold_P"}, p, ref_prod(s, a, b));
    endtask

    initial begin
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n8;
        int          lat;

        reset = 1'b1; start = 1'b0; sgn = 1'b0; mp = '0; mc = '0;
        start8 = 1'b0; sgn8 = 1'b0; mp8 = '0; mc8 = '0;
        #12;
        check("rst_P", p, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed products
        run_op(1'b0, 32'd999, 32'd999, "u999");
        check("u999_lit", p, 64'd998001);
        run_op(1'b1, 32'hFFFF_FFFD, 32'd7, "s_m3x7");
        check("s_m3x7_lit", p, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, "s_minmin");
        check("s_minmin_lit", p, 64'h4000_0000_0000_0000);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u_max");
        check("u_max_lit", p, 64'hFFFF_FFFE_0000_0001);

        // 8-bit instance
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; mp8 = 8'hFF; mc8 = 8'hFF;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0; mp8 = 8'h00; mc8 = 8'h00;
        n8 = 0;
        do begin
            @(posedge clk); #1;
            n8++;
        end while (!done8 && n8 < TIMEOUT);
        check("w8_lat", 64'(n8), 64'd8);
        check("w8_P", 64'(p8), 64'hFE01);

        // start during RUN is ignored
        lat = ref_lat(1'b0, 32'd999);
        launch(1'b0, 32'd999, 32'd999);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; mp = 32'd7; mc = 32'd11;
        @(posedge clk); #1;
        check("ign_busy", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", lat - 5, 64'd998001);

        // start in DONE restarts immediately
        run_op(1'b0, 32'd12345, 32'd6789, "restart");

        // start held high: completion followed by restart with current operands
        ra = $urandom; rb = $urandom;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; mp = ra; mc = rb;
        @(posedge clk); #1;
        wait_done("heldA", ref_lat(1'b0, ra), ref_prod(1'b0, ra, rb));
        @(negedge clk);
        mp = 32'hDEAD_BEEF; mc = 32'h0000_1234; sgn = 1'b1;
        @(posedge clk); #1;
        check("heldB_done", 64'(done), 64'd0);
        check("heldB_busy", 64'(busy), 64'd1);
        check("heldB_Pkeep", p, ref_prod(1'b0, ra, rb));
        @(negedge clk);
        start = 1'b0;
        wait_done("heldB", ref_lat(1'b1, 32'hDEAD_BEEF), ref_prod(1'b1, 32'hDEAD_BEEF, 32'h0000_1234));

        // Asynchronous reset mid-operation
        launch(1'b0, $urandom | 32'h8000_0000, $urandom);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_P", p, 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b0, 32'd3, 32'd4, "post_rst");
        check("post_rst_lit", p, 64'd12);

        // Reset wins over simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1; mp = 32'd9; mc = 32'd9;
        @(posedge clk); #1;
        check("rst_start_busy", 64'(busy), 64'd0);
        check("rst_start_P", p, 64'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;

        // Small / zero multipliers (latency depends on the build)
        run_op(1'b0, 32'd5, 32'd999, "u5");
        check("u5_lit", p, 64'd4995);
        run_op(1'b0, 32'd0, 32'd999, "u0");
        run_op(1'b1, 32'd5, 32'd999, "s5");
        check("s5_lit", p, 64'd4995);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom);
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom;
            run_op(rs, ra, rb, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spm_mult_n.md
# spm_mult_n

Parametrised sequential shift-add multiplier, the successor to the fixed 32-bit serial/parallel multiplier. It takes a WIDTH-bit multiplier (MP) and a WIDTH-bit multiplicand (MC) and processes one multiplier bit per clock. It produces a 2·WIDTH-bit product in unsigned or two's-complement signed mode, selected per operation. It sits behind a start/done handshake in the datapath and holds its result until the next accepted start.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled on the rising edge of clk.
- sgn  input  1  1 = two's-complement signed, 0 = unsigned; latched with start.
- MP  input  WIDTH  multiplier; latched with start.
- MC  input  WIDTH  multiplicand; latched with start.
- P  output  2·WIDTH  product; registered, held until the next completion.
- done  output  1  level; high from completion until the next accepted start.
- busy  output  1  high while state is RUN.

## Operation
- States are IDLE, RUN and DONE.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE on the final step.
  - DONE→RUN on start.
- start is ignored in RUN.
- On an accepted start edge:
  - Latch MP, MC and sgn.
  - Clear the internal accumulator and bit counter.
  - Drive done←0 and busy←1.
  - P keeps its old value.
- Each RUN edge processes the current LSB of the multiplier shift register:
  - If the bit is set, add the multiplicand to the upper accumulator half.
  - Shift {acc, mp} right by one.
- Unsigned mode: the add is WIDTH+1 bits wide so the carry is shifted in; no overflow is possible.
- Signed mode:
  - The multiplicand is sign-extended to WIDTH+1 bits.
  - The partial sum is arithmetic-shifted.
  - On step WIDTH-1 (the MP sign bit), the multiplicand is subtracted instead of added.
  - The result is the exact two's-complement product, including −2^(WIDTH−1) × −2^(WIDTH−1).
- On the final step:
  - The full 2·WIDTH-bit result is written into P in the same edge.
  - State←DONE, done←1, busy←0.
- Changes to MP, MC or sgn after the start edge have no effect on the running operation.

## Timing
- Reset (asynchronous, immediate, including mid-operation):
  - State←IDLE.
  - P=0, done=0, busy=0.
  - Accumulator and counter←0.
  - The in-flight operation is discarded.
- Latency (baseline): start sampled at edge k → done and P valid after edge k+WIDTH.
- Throughput: one operation per WIDTH+1 cycles when start is re-asserted in DONE.
- start held high continuously: each completion is followed, on the next edge, by a restart with the operands present on that edge.
- Simultaneous reset and start: reset wins.

## Configuration
- SPM_EARLY_TERM_EN
  - Defined: in unsigned mode, a RUN edge on which the remaining unprocessed multiplier bits are all zero is the final step.
    - P takes the accumulator result realigned by the number of bits still outstanding.
    - Latency = max(1, index of MP's highest set bit + 1) cycles; MP=0 completes in 1 cycle with P=0.
    - Signed mode always takes WIDTH cycles.
  - Undefined: every operation takes exactly WIDTH cycles, regardless of operand values.

## Test plan
- WIDTH=32, macro off, sgn=0, MP=999, MC=999, start at edge k → done rises after edge k+32 with P=998001; busy high for edges k..k+31.
- WIDTH=32, sgn=1:
  - MP=32'hFFFF_FFFD, MC=7 → P=64'hFFFF_FFFF_FFFF_FFEB.
  - MP=MC=32'h8000_0000 → P=64'h4000_0000_0000_0000.
- WIDTH=32, sgn=0, MP=MC=32'hFFFF_FFFF → P=64'hFFFF_FFFE_0000_0001. With WIDTH=8, sgn=0, 8'hFF×8'hFF → P=16'hFE01.
- start pulsed again at edge k+5 during RUN with new operands → ignored; original product delivered at k+32. start in DONE → done falls on that edge and the new product follows 32 cycles later.
- reset asserted mid-clock 10 cycles into RUN → P=0, done=0, busy=0 immediately. After release, a start with MP=3, MC=4 → P=12.
- Macro on, sgn=0:
  - MP=5, MC=999 → done after 3 cycles, P=4995.
  - MP=0 → done after 1 cycle, P=0.
  - sgn=1, MP=5 → done after 32 cycles, P=4995.
